// File: rtl/preset_entry.sv
// -----------------------------------------------------------------------------
// preset_entry
//   Input side of the seconds clock. Four raw push-buttons are synchronised,
//   debounced and edge-detected. The resulting press events edit a two-digit
//   BCD preset: a units digit (0-9) and a decimal digit (0-MAX_DECIMAL). A
//   commit press offers the preset to the counter over a valid/ready handshake.
//   The digit outputs also drive the dec7seg displays while editing.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a button state flips
//   CNT_W            width of the debounce counters (and minimum repeat width)
//   MAX_DECIMAL      highest value of the decimal digit
//   REPEAT_CYCLES    auto-repeat period (only with PRESET_AUTOREPEAT_EN)
//
// Ports
//   clk_i             in   system clock, rising edge
//   rst_i             in   synchronous active-high reset
//   but0_i            in   raw button: increment selected digit
//   but1_i            in   raw button: decrement selected digit
//   but2_i            in   raw button: toggle unit/decimal selection
//   but3_i            in   raw button: commit preset
//   load_ready_i      in   counter accepts the preset this cycle
//   load_valid_o      out  preset offered to counter
//   unit_preset_o     out  BCD units digit
//   decimal_preset_o  out  BCD decimal digit
//   edit_decimal_o    out  1 = decimal digit selected, 0 = units digit
//
// Build option
//   PRESET_AUTOREPEAT_EN  when defined, a held inc/dec button generates an
//                         extra event every REPEAT_CYCLES cycles in EDIT.
//                         When undefined, one event per press and no repeat
//                         counter exists.
// -----------------------------------------------------------------------------
module preset_entry #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int MAX_DECIMAL     = 5,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       but0_i,
  input  logic       but1_i,
  input  logic       but2_i,
  input  logic       but3_i,
  input  logic       load_ready_i,
  output logic       load_valid_o,
  output logic [3:0] unit_preset_o,
  output logic [3:0] decimal_preset_o,
  output logic       edit_decimal_o
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       UNIT_MAX = 4'd9;
  localparam logic [3:0]       DEC_MAX  = 4'(MAX_DECIMAL);

  // Button indices inside the 4-bit vectors below.
  localparam int B_INC    = 0;
  localparam int B_DEC    = 1;
  localparam int B_SELECT = 2;
  localparam int B_COMMIT = 3;

  if (DEBOUNCE_CYCLES < 1 || MAX_DECIMAL < 1 || MAX_DECIMAL > 9 ||
      REPEAT_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("preset_entry: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    EDIT  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Wrapping digit arithmetic; any out-of-range input is pulled back into range.
  function automatic logic [3:0] inc_wrap(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] dec_wrap(input logic [3:0] d, input logic [3:0] top);
    return (d == 4'd0 || d > top) ? top : d - 4'd1;
  endfunction

  logic [3:0]       raw;
  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       stable_p2;
  logic [CNT_W-1:0] db_cnt [4];
  logic [3:0]       stable_d_p3;
  logic [3:0]       press_p3;
  logic [3:0]       rise;

  state_t     state;
  state_t     state_nx;
  logic [3:0] unit_r;
  logic [3:0] unit_nx;
  logic [3:0] decimal_r;
  logic [3:0] decimal_nx;
  logic       edit_dec_r;
  logic       edit_dec_nx;

  logic ev_commit;
  logic ev_select;
  logic ev_inc;
  logic ev_dec;

  assign raw  = {but3_i, but2_i, but1_i, but0_i};
  assign rise = stable_p2 & ~stable_d_p3;

  // ---- stage p0/p1: two-flop synchroniser ----
  // ---- stage p2: debounce, stable state flips after DEBOUNCE_CYCLES disagreeing cycles ----
  // ---- stage p3: rising-edge detect, registered press pulse ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      stable_p2   <= '0;
      stable_d_p3 <= '0;
      press_p3    <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] != stable_p2[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable_p2[i] <= sync_p1[i];
            db_cnt[i]    <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      stable_d_p3 <= stable_p2;
      press_p3    <= rise;
    end
  end

`ifdef PRESET_AUTOREPEAT_EN
  localparam int RPT_NEED = $clog2(REPEAT_CYCLES + 1);
  localparam int RPT_W    = (CNT_W > RPT_NEED) ? CNT_W : RPT_NEED;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt [2];
  logic [1:0]       rpt_p3;

  // ---- stage p3: auto-repeat pulses for held inc/dec, aligned with press_p3 ----
  // The counter restarts on the same edge that registers the press pulse, so
  // the first repeat lands exactly REPEAT_CYCLES after the press event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rpt_p3 <= '0;
      for (int i = 0; i < 2; i++) begin
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_p3[i] <= 1'b0;
        if (state != EDIT || !stable_p2[i] || rise[i]) begin
          rpt_cnt[i] <= '0;
        end else if (rpt_cnt[i] == RPT_LAST) begin
          rpt_cnt[i] <= '0;
          rpt_p3[i]  <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev_inc = press_p3[B_INC] | rpt_p3[B_INC];
  assign ev_dec = press_p3[B_DEC] | rpt_p3[B_DEC];
`else
  assign ev_inc = press_p3[B_INC];
  assign ev_dec = press_p3[B_DEC];
`endif

  assign ev_commit = press_p3[B_COMMIT];
  assign ev_select = press_p3[B_SELECT];

  // ---- stage p4: edit FSM and preset registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= EDIT;
      unit_r     <= 4'd0;
      decimal_r  <= 4'd0;
      edit_dec_r <= 1'b0;
    end else begin
      state      <= state_nx;
      unit_r     <= unit_nx;
      decimal_r  <= decimal_nx;
      edit_dec_r <= edit_dec_nx;
    end
  end

  // Only the highest-priority event of a cycle is acted on; events arriving
  // during OFFER are dropped rather than queued.
  always_comb begin
    state_nx    = state;
    unit_nx     = unit_r;
    decimal_nx  = decimal_r;
    edit_dec_nx = edit_dec_r;
    case (state)
      EDIT: begin
        if (ev_commit) begin
          state_nx = OFFER;
        end else if (ev_select) begin
          edit_dec_nx = ~edit_dec_r;
        end else if (ev_inc) begin
          if (edit_dec_r) decimal_nx = inc_wrap(decimal_r, DEC_MAX);
          else            unit_nx    = inc_wrap(unit_r, UNIT_MAX);
        end else if (ev_dec) begin
          if (edit_dec_r) decimal_nx = dec_wrap(decimal_r, DEC_MAX);
          else            unit_nx    = dec_wrap(unit_r, UNIT_MAX);
        end
      end
      OFFER: begin
        if (load_ready_i) begin
          state_nx    = EDIT;
          edit_dec_nx = 1'b0;
        end
      end
      default: begin
        state_nx = EDIT;
      end
    endcase
  end

  assign load_valid_o     = (state == OFFER);
  assign unit_preset_o    = unit_r;
  assign decimal_preset_o = decimal_r;
  assign edit_decimal_o   = edit_dec_r;

endmodule

// File: tb/tb_preset_entry.sv
// -----------------------------------------------------------------------------
// tb_preset_entry
//   Directed bench for preset_entry with DEBOUNCE_CYCLES=4, MAX_DECIMAL=5,
//   REPEAT_CYCLES=8. A cycle-level behavioural model of the button timing and
//   the edit rules runs alongside the DUT and is compared on every falling
//   edge; literal expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_preset_entry;

  localparam int DB   = 4;
  localparam int MAXD = 5;
  localparam int RPT  = 8;

  logic       clk;
  logic       rst;
  logic [3:0] but;
  logic       load_ready;
  logic       load_valid;
  logic [3:0] unit;
  logic [3:0] dec;
  logic       sel;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  preset_entry #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (16),
    .MAX_DECIMAL    (MAXD),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .but0_i          (but[0]),
    .but1_i          (but[1]),
    .but2_i          (but[2]),
    .but3_i          (but[3]),
    .load_ready_i    (load_ready),
    .load_valid_o    (load_valid),
    .unit_preset_o   (unit),
    .decimal_preset_o(dec),
    .edit_decimal_o  (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button timing: a raw level reaches the debouncer two edges after it is
  // sampled; the accepted level changes after DB consecutive disagreeing
  // samples; a 0->1 change becomes an event visible one edge later, and the
  // edit rules act on it at the edge after that.
  int m_unit;
  int m_dec;
  bit m_sel;
  bit m_offer;
  bit m_h1 [4];
  bit m_h2 [4];
  bit m_stable [4];
  bit m_rose_prev [4];
  bit m_evt [4];
  int m_run [4];
  int m_since [2];

  always @(posedge clk) begin
    bit offer_before;
    bit rep [2];
    bit seen;
    bit rose;
    started = 1'b1;
    if (rst) begin
      m_unit  = 0;
      m_dec   = 0;
      m_sel   = 0;
      m_offer = 0;
      for (int b = 0; b < 4; b++) begin
        m_h1[b] = 0; m_h2[b] = 0; m_stable[b] = 0;
        m_rose_prev[b] = 0; m_evt[b] = 0; m_run[b] = 0;
      end
      m_since[0] = 0;
      m_since[1] = 0;
    end else begin
      offer_before = m_offer;
      if (!m_offer) begin
        if (m_evt[3])      m_offer = 1;
        else if (m_evt[2]) m_sel = !m_sel;
        else if (m_evt[0]) begin
          if (m_sel) m_dec = (m_dec + 1) % (MAXD + 1);
          else       m_unit = (m_unit + 1) % 10;
        end else if (m_evt[1]) begin
          if (m_sel) m_dec = (m_dec + MAXD) % (MAXD + 1);
          else       m_unit = (m_unit + 9) % 10;
        end
      end else if (load_ready) begin
        m_offer = 0;
        m_sel   = 0;
      end
      rep[0] = 0;
      rep[1] = 0;
`ifdef PRESET_AUTOREPEAT_EN
      for (int b = 0; b < 2; b++) begin
        if (offer_before || !m_stable[b] || m_rose_prev[b]) m_since[b] = 0;
        else begin
          m_since[b]++;
          if (m_since[b] == RPT) begin
            rep[b] = 1;
            m_since[b] = 0;
          end
        end
      end
`endif
      for (int b = 0; b < 4; b++)
        m_evt[b] = m_rose_prev[b] | ((b < 2) ? rep[b % 2] : 1'b0);
      for (int b = 0; b < 4; b++) begin
        seen  = m_h2[b];
        m_h2[b] = m_h1[b];
        m_h1[b] = but[b];
        rose  = 0;
        if (seen != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_stable[b] = seen;
            m_run[b] = 0;
            rose = seen;
          end
        end else begin
          m_run[b] = 0;
        end
        m_rose_prev[b] = rose;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_valid",   load_valid, m_offer);
      chk("model_unit",    unit,       m_unit);
      chk("model_decimal", dec,        m_dec);
      chk("model_select",  sel,        m_sel);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    but = mask;
    step(10);
    but = 4'b0000;
    step(10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    but = 4'b0000;
    load_ready = 1'b0;

    // reset state
    step(3);
    chk("rst_unit", unit, 0);
    chk("rst_decimal", dec, 0);
    chk("rst_select", sel, 0);
    chk("rst_valid", load_valid, 0);
    rst = 1'b0;
    step(2);

    // bouncing press: one increment, 8 edges after the last rising raw edge
    but[0] = 1'b1; step(1);
    but[0] = 1'b0; step(1);
    but[0] = 1'b1;
    step(7);
    chk("bounce_before", unit, 0);
    step(1);
    chk("bounce_after", unit, 1);
    step(2);
    but[0] = 1'b0;
    step(10);
    chk("bounce_single", unit, 1);

    // units wrap up and down (load_ready high in EDIT must be ignored)
    do_reset();
    load_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      press(4'b0001);
      chk("unit_inc", unit, i % 10);
    end
    press(4'b0010);
    chk("unit_wrap_down", unit, 9);
    chk("unit_dec_untouched", dec, 0);
    chk("no_offer_in_edit", load_valid, 0);
    load_ready = 1'b0;

    // decimal editing and wrap at MAX_DECIMAL
    press(4'b0100);
    chk("select_decimal", sel, 1);
    for (int i = 1; i <= 6; i++) begin
      press(4'b0001);
      chk("decimal_inc", dec, i % 6);
    end
    chk("decimal_unit_kept", unit, 9);
    press(4'b0010);
    chk("decimal_wrap_down", dec, 5);

    // same-cycle priority: inc beats dec, select beats inc
    press(4'b0011);
    chk("prio_inc_over_dec", dec, 0);
    press(4'b0101);
    chk("prio_select", sel, 0);
    chk("prio_select_dec", dec, 0);
    press(4'b0100);
    chk("reselect", sel, 1);

    // commit with counter not ready, ignored press, then transfer
    press(4'b1000);
    chk("offer_valid", load_valid, 1);
    press(4'b0001);
    chk("offer_held", load_valid, 1);
    chk("offer_unit_frozen", unit, 9);
    chk("offer_dec_frozen", dec, 0);
    step(5);
    load_ready = 1'b1;
    step(1);
    load_ready = 1'b0;
    chk("xfer_valid_low", load_valid, 0);
    chk("xfer_select_clear", sel, 0);
    chk("xfer_unit_kept", unit, 9);
    step(10);
    chk("xfer_not_queued", unit, 9);

    // commit beats inc, then reset aborts the offer
    press(4'b1001);
    chk("prio_commit", load_valid, 1);
    chk("prio_commit_unit", unit, 9);
    rst = 1'b1;
    step(1);
    chk("abort_valid", load_valid, 0);
    chk("abort_unit", unit, 0);
    rst = 1'b0;
    step(2);

    // long hold of inc
    but[0] = 1'b1;
    step(30);
    but[0] = 1'b0;
    step(12);
`ifdef PRESET_AUTOREPEAT_EN
    chk("hold_increments", unit, 4);
`else
    chk("hold_increments", unit, 1);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
